// File: rtl/expr_pipe_eval.sv
// expr_pipe_eval: 16-op mixed-sign evaluator feeding an elastic valid/ready pipeline.
// Slot 0 captures the evaluated result; later slots only move it toward the output.
module expr_pipe_eval #(
    parameter int W = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic         sgn,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [3:0]   flags,
    output logic [15:0]  ops_done
);
    logic [W:0]        sum, dif, sra;
    logic [2*W-1:0]    prod;
    logic              lt, eq, fill, mulov, c, o;
    logic [W-1:0]      r;
    logic [STAGES-1:0] v, ld;
    logic [W+3:0]      d [STAGES];

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        prod = (sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a}) * (sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b});
        mulov = sgn ? (prod[2*W-1:W] != {W{prod[W-1]}}) : |prod[2*W-1:W];
        fill = sgn & a[W-1];
        // one extra fill bit makes oversized shift amounts saturate to all-fill
        sra = $signed({fill, a}) >>> b;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        eq = a == b;
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'd0: begin
                r = sum[W-1:0];
                c = sum[W];
                o = sgn & (a[W-1] == b[W-1]) & (sum[W-1] != a[W-1]);
            end
            4'd1: begin
                r = dif[W-1:0];
                c = dif[W];
                o = sgn & (a[W-1] != b[W-1]) & (dif[W-1] != a[W-1]);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a ^ b);
            4'd6:  r = a << b;
            4'd7:  r = a >> b;
            4'd8:  r = sra[W-1:0];
            4'd9:  r = {{(W-1){1'b0}}, lt};
            4'd10: r = {{(W-1){1'b0}}, lt | eq};
            4'd11: r = {{(W-1){1'b0}}, eq};
            4'd12: r = {{(W-1){1'b0}}, &a};
            4'd13: r = {{(W-1){1'b0}}, |a};
            4'd14: r = {{(W-1){1'b0}}, ^a};
            default: begin
                r = prod[W-1:0];
                o = mulov;
            end
        endcase
    end

    // a slot may load if the output accepts or any slot at or beyond it is empty
    always_comb begin
        ld = '0;
        for (int k = 0; k < STAGES; k++)
            ld[k] = out_ready | ~&(v | STAGES'((1 << k) - 1));
    end

    assign in_ready  = rst_n & ld[0];
    assign out_valid = v[STAGES-1];
    assign y         = d[STAGES-1][W+3:4];
    assign flags     = d[STAGES-1][3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            ops_done <= '0;
            for (int k = 0; k < STAGES; k++) d[k] <= '0;
        end else begin
            if (out_valid && out_ready) ops_done <= ops_done + 16'd1;
            if (ld[0]) begin
                v[0] <= in_valid;
                if (in_valid) d[0] <= {r, ~|r, sgn & r[W-1], c, o};
            end
            for (int k = 1; k < STAGES; k++)
                if (ld[k]) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
        end
    end
endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb_expr_pipe_eval: directed vector table plus backpressure and mid-flight reset sequences.
module tb_expr_pipe_eval;
    localparam int W = 6;
    localparam int NV = 24;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, sgn = 0;
    logic in_ready, out_valid;
    logic [3:0] op = 0, flags;
    logic [W-1:0] a = 0, b = 0, y;
    logic [15:0] ops_done;
    int total = 0, bad = 0;

    typedef struct packed {
        logic [3:0]   op;
        logic         sgn;
        logic [W-1:0] a, b, y;
        logic [3:0]   f;
    } vec_t;
    vec_t vt [NV];

    expr_pipe_eval #(.W(W), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sgn(sgn), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .flags(flags), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int tx, rx, first, last, seen;
        // {op, sgn, a, b, y, flags{zero,neg,carry,ovf}}
        vt[0]  = '{4'd0,  1'b1, 6'h1F, 6'h01, 6'h20, 4'b0101};
        vt[1]  = '{4'd1,  1'b0, 6'h03, 6'h05, 6'h3E, 4'b0010};
        vt[2]  = '{4'd1,  1'b1, 6'h03, 6'h05, 6'h3E, 4'b0110};
        vt[3]  = '{4'd8,  1'b1, 6'h30, 6'h02, 6'h3C, 4'b0100};
        vt[4]  = '{4'd8,  1'b1, 6'h30, 6'h09, 6'h3F, 4'b0100};
        vt[5]  = '{4'd6,  1'b0, 6'h15, 6'h06, 6'h00, 4'b1000};
        vt[6]  = '{4'd7,  1'b1, 6'h30, 6'h02, 6'h0C, 4'b0000};
        vt[7]  = '{4'd9,  1'b1, 6'h3F, 6'h01, 6'h01, 4'b0000};
        vt[8]  = '{4'd9,  1'b0, 6'h3F, 6'h01, 6'h00, 4'b1000};
        vt[9]  = '{4'd15, 1'b0, 6'h08, 6'h08, 6'h00, 4'b1001};
        vt[10] = '{4'd14, 1'b0, 6'h07, 6'h00, 6'h01, 4'b0000};
        vt[11] = '{4'd0,  1'b0, 6'h3F, 6'h01, 6'h00, 4'b1010};
        vt[12] = '{4'd2,  1'b0, 6'h2A, 6'h0F, 6'h0A, 4'b0000};
        vt[13] = '{4'd5,  1'b0, 6'h2A, 6'h15, 6'h00, 4'b1000};
        vt[14] = '{4'd15, 1'b1, 6'h3F, 6'h3F, 6'h01, 4'b0000};
        vt[15] = '{4'd15, 1'b1, 6'h10, 6'h04, 6'h00, 4'b1001};
        vt[16] = '{4'd11, 1'b0, 6'h2A, 6'h2A, 6'h01, 4'b0000};
        vt[17] = '{4'd10, 1'b1, 6'h20, 6'h1F, 6'h01, 4'b0000};
        vt[18] = '{4'd12, 1'b0, 6'h3F, 6'h00, 6'h01, 4'b0000};
        vt[19] = '{4'd13, 1'b0, 6'h00, 6'h00, 6'h00, 4'b1000};
        vt[20] = '{4'd8,  1'b0, 6'h30, 6'h02, 6'h0C, 4'b0000};
        vt[21] = '{4'd3,  1'b1, 6'h21, 6'h12, 6'h33, 4'b0100};
        vt[22] = '{4'd4,  1'b0, 6'h3C, 6'h0F, 6'h33, 4'b0000};
        vt[23] = '{4'd1,  1'b1, 6'h20, 6'h01, 6'h1F, 4'b0001};

        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_y", y, 0);
        check("rst_flags", flags, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < NV; i++) begin
            in_valid = 1; op = vt[i].op; sgn = vt[i].sgn; a = vt[i].a; b = vt[i].b;
            #1;
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            @(negedge clk);
            in_valid = 0;
            check($sformatf("v%0d_early", i), out_valid, 0);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_y", i), y, vt[i].y);
            check($sformatf("v%0d_flags", i), flags, vt[i].f);
        end
        @(negedge clk);
        check("vec_ops_done", ops_done, NV);

        // backpressure: 5 ADDs streamed, output stalled for the first 4 cycles
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("bp_ops_done_rst", ops_done, 0);
        tx = 0; rx = 0; first = -1; last = -1;
        for (int c = 0; c < 20 && rx < 5; c++) begin
            in_valid = tx < 5; op = 4'd0; sgn = 0; a = 6'(tx + 3); b = 6'h0A;
            out_ready = c >= 4;
            #1;
            if (c == 2) check("bp_in_ready_low", in_ready, 0);
            if (c == 4) check("bp_accepted_before_release", tx, 2);
            if (out_valid) check($sformatf("bp_y%0d_c%0d", rx, c), y, rx + 13);
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                last = c;
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(negedge clk);
        end
        in_valid = 0;
        check("bp_received", rx, 5);
        check("bp_sent", tx, 5);
        check("bp_back_to_back", last - first, 4);
        check("bp_no_dup", out_valid, 0);
        check("bp_ops_done", ops_done, 5);

        // two results in flight, then an asynchronous reset pulse
        out_ready = 0;
        in_valid = 1; op = 4'd0; sgn = 0; a = 6'h01; b = 6'h01;
        @(negedge clk);
        a = 6'h02; b = 6'h02;
        @(negedge clk);
        in_valid = 0;
        check("mr_loaded", out_valid, 1);
        #2;
        rst_n = 0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_ops_done", ops_done, 0);
        check("mr_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        in_valid = 1; a = 6'h07; b = 6'h08;
        @(negedge clk);
        in_valid = 0;
        check("mr_early", out_valid, 0);
        @(negedge clk);
        check("mr_valid", out_valid, 1);
        check("mr_y", y, 6'h0F);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mr_stale_results", seen, 0);
        check("mr_ops_done_end", ops_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
